inst_fetch_ctrl: RTL

Instruction-fetch controller for the five-stage pipelined CPU. It owns the program counter and drives the address of the combinational 64 x 32 instruction ROM. It captures the fetched word into the IF/ID pipeline register and sequences the fetch stream through:

- reset start-up at address 0x01;
- load-use stalls;
- taken branches and jumps, with wrong-path squash;
- a halt/resume control used by the debug bench.

---
 rtl/inst_fetch_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the instruction ROM address and
// sequences the IF/ID register through boot, stalls, redirects and halt.
module inst_fetch_ctrl #(
   parameter logic [5:0]  START_ADDR = 6'h01,
   parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [5:0]  br_npc,
   input  logic [15:0] br_offset,
   input  logic        jmp,
   input  logic [25:0] jmp_target,
   input  logic        halt_req,
   output logic [5:0]  rom_a,
   input  logic [31:0] rom_inst,
   output logic [31:0] if_id_inst,
   output logic [5:0]  if_id_npc,
   output logic        if_id_valid,
   output logic        id_flush,
   output logic [15:0] fetch_cnt,
   output logic        halted
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t      state, state_nx;
   logic [5:0]  pc, pc_nx;
   logic [31:0] inst_nx;
   logic [5:0]  npc_nx;
   logic        valid_nx;
   logic        flush_nx;
   logic [15:0] cnt_nx;
   logic        unused_bits;

   // Only the low six bits of the offset and jump field can address the ROM.
   assign unused_bits = ^{br_offset[15:6], jmp_target[25:6]};

   assign rom_a  = pc;
   assign halted = (state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= START_ADDR;
         if_id_inst  <= NOP_WORD;
         if_id_npc   <= 6'd0;
         if_id_valid <= 1'b0;
         id_flush    <= 1'b0;
         fetch_cnt   <= 16'd0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         if_id_inst  <= inst_nx;
         if_id_npc   <= npc_nx;
         if_id_valid <= valid_nx;
         id_flush    <= flush_nx;
         fetch_cnt   <= cnt_nx;
      end
   end

   // Redirects outrank stall so a squashed wrong-path fetch can never be held in IF/ID.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      inst_nx  = if_id_inst;
      npc_nx   = if_id_npc;
      valid_nx = if_id_valid;
      flush_nx = 1'b0;
      cnt_nx   = fetch_cnt;
      case (state)
         BOOT: begin
            state_nx = RUN;
         end
         RUN: begin
            if (br_taken) begin
               pc_nx    = br_npc + br_offset[5:0];
               inst_nx  = NOP_WORD;
               npc_nx   = 6'd0;
               valid_nx = 1'b0;
               flush_nx = 1'b1;
            end else if (jmp) begin
               pc_nx    = jmp_target[5:0];
               inst_nx  = NOP_WORD;
               npc_nx   = 6'd0;
               valid_nx = 1'b0;
            end else if (stall) begin
               pc_nx = pc;
            end else if (halt_req) begin
               state_nx = HALT;
               inst_nx  = NOP_WORD;
               npc_nx   = 6'd0;
               valid_nx = 1'b0;
            end else begin
               inst_nx  = rom_inst;
               npc_nx   = pc + 6'd1;
               valid_nx = 1'b1;
               pc_nx    = pc + 6'd1;
               if (fetch_cnt != 16'hFFFF) begin
                  cnt_nx = fetch_cnt + 16'd1;
               end
            end
         end
         HALT: begin
            inst_nx  = NOP_WORD;
            npc_nx   = 6'd0;
            valid_nx = 1'b0;
            if (!halt_req) begin
               state_nx = RUN;
            end
         end
         default: begin
            state_nx = BOOT;
         end
      endcase
   end

endmodule
